// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared data-memory access types and alignment helper
package dmem_pkg;

  localparam int XLEN        = 32;
  localparam int AC_ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [2:0]      ac;
    logic [XLEN-1:0] wd;
  } dmem_req_t;

  // Illegal size encoding or an address that is not naturally aligned for the size.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-requester load/store request and response bus
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_we;
  logic [1:0][DATA_WIDTH-1:0] req_addr;
  logic [1:0][2:0]            req_ac;
  logic [1:0][DATA_WIDTH-1:0] req_wd;
  logic [1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]      resp_rdata;
  logic                       resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_ac, req_wd,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_ac, req_wd,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin or fixed-priority grant
module rr_arbiter2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Single requester wins outright; on contention favour the port not granted last.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (RR_EN && !last_grant_q) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_grant_d = advance_i ? grant_o[1] : last_grant_q;

  // Remember who was served; starting at 1 lets port 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrated, range-checked access controller for data_mem
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int MEM_ADDR_BITS = 17,
  parameter bit RR_EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         bus,
  output logic [DATA_WIDTH-1:0] mem_a_o,
  output logic                  mem_we_o,
  output logic [2:0]            mem_ac_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  logic [1:0]            grant;
  logic [1:0]            ready;
  logic                  handshake;

  dmem_req_t             slot_d;
  logic                  slot_port_d;
  logic                  slot_err_d;

  dmem_req_t             slot_q;
  logic                  slot_vld_q;
  logic                  slot_port_q;
  logic                  slot_err_q;

  logic [1:0]            resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid),
    .advance_i (handshake),
    .grant_o   (grant)
  );

  // The slot always drains in the cycle after it loads, so the grant alone decides readiness.
  assign ready         = grant & {2{rst_n}};
  assign handshake     = |(ready & bus.req_valid);
  assign bus.req_ready = ready;

  // Select the granted request and classify it before it enters the slot.
  always_comb begin
    slot_port_d = ready[1];
    slot_d.we   = bus.req_we[slot_port_d];
    slot_d.addr = bus.req_addr[slot_port_d];
    slot_d.ac   = bus.req_ac[slot_port_d];
    slot_d.wd   = bus.req_wd[slot_port_d];
    slot_err_d  = misaligned(slot_d.addr[1:0], slot_d.ac[1:0])
                | (|slot_d.addr[XLEN-1:MEM_ADDR_BITS]);
  end

  // Request slot: payload only changes on a handshake, so memory inputs hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= 1'b0;
      slot_port_q <= 1'b0;
      slot_err_q  <= 1'b0;
      slot_q      <= '0;
    end else begin
      slot_vld_q <= handshake;
      if (handshake) begin
        slot_port_q <= slot_port_d;
        slot_err_q  <= slot_err_d;
        slot_q      <= slot_d;
      end
    end
  end

  assign mem_a_o  = slot_q.addr;
  assign mem_ac_o = slot_q.ac;
  assign mem_wd_o = slot_q.wd;
  assign mem_we_o = slot_vld_q & slot_q.we & ~slot_err_q;

  // One-cycle response; read data only for a clean load, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 2'b00;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= slot_vld_q ? (slot_port_q ? 2'b10 : 2'b01) : 2'b00;
      resp_err_q   <= slot_vld_q & slot_err_q;
      resp_rdata_q <= (slot_vld_q & ~slot_q.we & ~slot_err_q) ? mem_rd_i : '0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester access controller for the single-port byte-addressed data memory (`data_mem`). It accepts load/store requests from the pipeline MEM stage (port 0) and from the debug/DMA loader (port 1) over valid/ready handshakes, arbitrates between them, and checks alignment and range. It drives the memory's address/WE/AddressingControl/WD inputs from a registered request and returns registered read data plus an error flag. It sits between both requesters and `data_mem`; the memory is its only downstream.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `MEM_ADDR_BITS`, 17, implemented address bits (128 KB); higher set bits are out of range
- `RR_EN`, 1, 1 = round-robin, 0 = fixed priority to port 0

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid[1:0]`  in  2  request pending, per port
- `req_ready[1:0]`  out  2  request accepted this cycle, per port
- `req_we[1:0]`  in  2  1 = store, 0 = load
- `req_addr[p]`  in  32 ×2  byte address
- `req_ac[p]`  in  3 ×2  [1:0] size (00 byte, 01 half, 10 word), [2] zero-extend
- `req_wd[p]`  in  32 ×2  store data
- `resp_valid[1:0]`  out  2  one-cycle response strobe, per port
- `resp_rdata`  out  32  load data (0 for stores and errors)
- `resp_err`  out  1  misaligned, out-of-range or size 11
- `mem_a`  out  32  to data memory A
- `mem_we`  out  1  to data memory WE
- `mem_ac`  out  3  to data memory AddressingControl
- `mem_wd`  out  32  to data memory WD
- `mem_rd`  in  32  from data memory RD (combinational)

## Operation
- Registered request slot: `slot_vld`, `slot_port`, `slot_we`, `slot_addr`, `slot_ac`, `slot_wd`, `slot_err`.
- Slot loads when exactly one `req_ready` bit is high and the matching `req_valid` is high (a handshake). At most one `req_ready` bit is high per cycle.
- `req_ready[p]` = arbiter grant to `p` AND (`!slot_vld` OR slot is completing this cycle). The slot always completes in the cycle after it loads, so the rate is one accepted request per cycle.
- Arbitration when both ports are valid:
  - `RR_EN=1`: grant the port not granted last. `last_grant` resets to 1, so port 0 wins first.
  - `RR_EN=0`: port 0 always wins.
  - A single valid port is granted immediately.
- `slot_err` is computed at accept time. It is set if size = 11, half with `addr[0]=1`, word with `addr[1:0]!=0`, or any of `addr[31:MEM_ADDR_BITS]` nonzero.
- Access cycle (`slot_vld=1`):
  - `mem_a`/`mem_ac`/`mem_wd` are driven from the slot.
  - `mem_we = slot_we & !slot_err`.
  - `mem_rd` is captured into `resp_rdata` only for a load without error; otherwise `resp_rdata` is 0.
- Idle (`slot_vld=0`): `mem_we=0`, and `mem_a`, `mem_ac`, `mem_wd` are held at their last value.
- Response registers: `resp_valid[slot_port]`, `resp_err` and `resp_rdata` are set at the end of the access cycle and held for exactly one cycle.

## Timing
- Handshake at edge N → access in cycle N+1 (store written at edge N+2) → `resp_valid` high in cycle N+2.
- Load-to-use latency is 2 cycles. Back-to-back throughput is 1 per cycle.
- Store then load to the same address on consecutive accepts: the load returns the new data, because the write commits at the edge before the load's access cycle.
- A requester must hold `req_*` stable while valid and not ready. Dropping valid before ready is permitted and accepts nothing.
- Reset (asynchronous, mid-operation included):
  - `slot_vld=0`, so any pending access is dropped with no write and no response.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`.
  - `mem_we=0`, `mem_a=0`, `mem_ac=0`, `mem_wd=0`.
  - `req_ready=0` while `rst_n` is low; `last_grant=1`.
- An erroring request consumes a slot and a response cycle like a normal access; it never asserts `mem_we`.

## Structure
- Shared package `dmem_pkg`:
  - `size_e` enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`).
  - `AC_ZEXT_BIT=2`.
  - A `dmem_req_t` struct (`we`, `addr`, `ac`, `wd`).
  - `function misaligned(addr, ac)`, shared with the memory-stage hazard logic.
- One sub-module, `rr_arbiter2`: 2-way grant with `last_grant` state, a `RR_EN` parameter, and an `advance` input pulsed on handshake.

## Test plan
- Port 0 load word at 0x0 (`ac=010`) with port 1 idle → `resp_valid[0]` 2 cycles later, `resp_rdata=0x12345678`, `resp_err=0`.
- Port 0 store word 0x11223344 to 0x100, followed next cycle by a load word at 0x100 → load response `0x11223344`; `mem_we` high for exactly one cycle.
- Both ports valid for 4 cycles with `RR_EN=1` → grants 0,1,0,1. With `RR_EN=0` → grants 0,0,0,0 and port 1 waits.
- Load byte at 0x11: `ac=000` → `0xFFFFFF80`; `ac=100` → `0x00000080`. Load half at 0x22 signed → `0xFFFF8000`.
- Word store at 0x102 and a load at 0x00020000 → `resp_err=1`, `resp_rdata=0`, `mem_we` stays 0, and memory at 0x100..0x103 still reads `0xAAAAAAAA`.
- Assert `rst_n` low in the access cycle of a store to 0x104 → no write (0x104 still reads `0xAAAAAAAA`), no `resp_valid`, and all outputs at their reset values.
